// File: rtl/mdu_iter_if.sv
// rtl/mdu_iter_if.sv - start/ready handshake bundle between EX and the iterative multiply/divide unit
// div_zero_o exists only when MDU_DIVZERO_FLAG_EN is defined.
interface mdu_iter_if #(parameter int WIDTH = 32);
  logic                   start_i;
  logic                   annul_i;
  logic [1:0]             op_i;
  logic [WIDTH-1:0]       opdata1_i;
  logic [WIDTH-1:0]       opdata2_i;
  logic [2*WIDTH-1:0]     result_o;
  logic                   ready_o;
  logic                   busy_o;
`ifdef MDU_DIVZERO_FLAG_EN
  logic                   div_zero_o;

  modport master (output start_i, annul_i, op_i, opdata1_i, opdata2_i,
                  input  result_o, ready_o, busy_o, div_zero_o);
  modport slave  (input  start_i, annul_i, op_i, opdata1_i, opdata2_i,
                  output result_o, ready_o, busy_o, div_zero_o);
`else
  modport master (output start_i, annul_i, op_i, opdata1_i, opdata2_i,
                  input  result_o, ready_o, busy_o);
  modport slave  (input  start_i, annul_i, op_i, opdata1_i, opdata2_i,
                  output result_o, ready_o, busy_o);
`endif
endinterface

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative shift-add multiplier / restoring divider, signed and unsigned
// Optional zero-divisor flag output under MDU_DIVZERO_FLAG_EN.
module mdu_iter #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  mdu_iter_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   dsr_q, dsr_d;
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
`ifdef MDU_DIVZERO_FLAG_EN
  logic               dz_q, dz_d;
`endif

  logic               s1, s2;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] iter_next, fixed;
  logic [WIDTH-1:0]   q_raw, r_raw;

  // Multiply keeps {partial_hi, multiplier} in work_q with the multiplicand in dsr_q;
  // divide keeps {remainder, dividend/quotient} with the divisor in dsr_q.
  always_comb begin
    s1       = bus.op_i[0] & bus.opdata1_i[WIDTH-1];
    s2       = bus.op_i[0] & bus.opdata2_i[WIDTH-1];
    a_mag    = s1 ? -bus.opdata1_i : bus.opdata1_i;
    b_mag    = s2 ? -bus.opdata2_i : bus.opdata2_i;

    mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, dsr_q} : '0);
    div_sh   = work_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_sh - {1'b0, dsr_q};
    div_ge   = ~div_diff[WIDTH];

    if (op_q[1])
      iter_next = {(div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]), work_q[WIDTH-2:0], div_ge};
    else
      iter_next = {mul_sum, work_q[WIDTH-1:1]};

    r_raw = iter_next[2*WIDTH-1:WIDTH];
    q_raw = iter_next[WIDTH-1:0];
    if (op_q[1])
      fixed = {(rneg_q ? -r_raw : r_raw), (neg_q ? -q_raw : q_raw)};
    else
      fixed = neg_q ? -iter_next : iter_next;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    dsr_d    = dsr_q;
    work_d   = work_q;
    result_d = result_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
`ifdef MDU_DIVZERO_FLAG_EN
    dz_d     = dz_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start_i && !bus.annul_i) begin
          op_d   = bus.op_i;
          neg_d  = s1 ^ s2;
          rneg_d = s1;
          cnt_d  = '0;
          if (bus.op_i[1] && bus.opdata2_i == '0) begin
            state_d  = DONE;
            result_d = '0;
`ifdef MDU_DIVZERO_FLAG_EN
            dz_d     = 1'b1;
`endif
          end else begin
            state_d = CALC;
            if (bus.op_i[1]) begin
              dsr_d  = b_mag;
              work_d = {{WIDTH{1'b0}}, a_mag};
            end else begin
              dsr_d  = a_mag;
              work_d = {{WIDTH{1'b0}}, b_mag};
            end
          end
        end
      end
      CALC: begin
        if (bus.annul_i) begin
          state_d = IDLE;
        end else begin
          work_d = iter_next;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            result_d = fixed;
            state_d  = DONE;
          end
        end
      end
      DONE: begin
        if (bus.annul_i || !bus.start_i) begin
          state_d = IDLE;
`ifdef MDU_DIVZERO_FLAG_EN
          dz_d    = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      dsr_q    <= '0;
      work_q   <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
`ifdef MDU_DIVZERO_FLAG_EN
      dz_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      dsr_q    <= dsr_d;
      work_q   <= work_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
`ifdef MDU_DIVZERO_FLAG_EN
      dz_q     <= dz_d;
`endif
    end
  end

  assign bus.result_o = result_q;
  assign bus.busy_o   = (state_q == CALC);
  assign bus.ready_o  = (state_q == DONE);
`ifdef MDU_DIVZERO_FLAG_EN
  assign bus.div_zero_o = dz_q;
`endif
endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - directed bench for mdu_iter at WIDTH=32 and WIDTH=8 driven in lockstep
// Honours MDU_DIVZERO_FLAG_EN for the div_zero_o checks.
module tb_mdu_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic        annul = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic [63:0] pend32 = 64'd0, held32 = 64'd0;
  logic [15:0] pend8  = 16'd0, held8  = 16'd0;

  mdu_iter_if #(.WIDTH(32)) bus32 ();
  mdu_iter_if #(.WIDTH(8))  bus8 ();

  assign bus32.start_i   = start;
  assign bus32.annul_i   = annul;
  assign bus32.op_i      = op;
  assign bus32.opdata1_i = a;
  assign bus32.opdata2_i = b;
  assign bus8.start_i    = start;
  assign bus8.annul_i    = annul;
  assign bus8.op_i       = op;
  assign bus8.opdata1_i  = a[7:0];
  assign bus8.opdata2_i  = b[7:0];

  mdu_iter #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  mdu_iter #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result from plain integer arithmetic on w-bit operands.
  function automatic logic [63:0] model(input int w, input logic [1:0] o,
                                        input logic [31:0] x, input logic [31:0] y);
    logic [63:0] mw, m2, ux, uy, q, r;
    longint sx, sy;
    mw = (64'd1 << w) - 64'd1;
    m2 = (w == 32) ? '1 : (64'd1 << (2 * w)) - 64'd1;
    ux = {32'd0, x} & mw;
    uy = {32'd0, y} & mw;
    sx = ux[w-1] ? longint'(ux) - longint'(mw) - 1 : longint'(ux);
    sy = uy[w-1] ? longint'(uy) - longint'(mw) - 1 : longint'(uy);
    case (o)
      2'd0: return (ux * uy) & m2;
      2'd1: return 64'(sx * sy) & m2;
      2'd2: begin
        if (uy == 64'd0) return 64'd0;
        q = ux / uy;
        r = ux % uy;
      end
      default: begin
        if (sy == 0) return 64'd0;
        q = 64'(sx / sy);
        r = 64'(sx % sy);
      end
    endcase
    return ((r & mw) << w) | (q & mw);
  endfunction

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("excl32", 64'(bus32.ready_o & bus32.busy_o), 64'd0);
      check("excl8",  64'(bus8.ready_o & bus8.busy_o), 64'd0);
      if (bus32.ready_o) begin
        check("result32", bus32.result_o, pend32);
        held32 = pend32;
      end else begin
        check("hold32", bus32.result_o, held32);
      end
      if (bus8.ready_o) begin
        check("result8", 64'(bus8.result_o), 64'(pend8));
        held8 = pend8;
      end else begin
        check("hold8", 64'(bus8.result_o), 64'(held8));
      end
    end
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] lit32, input logic [15:0] lit8, input int annul_at);
    int n32, n8, k;
    bit dz32, dz8;
    logic [63:0] keep32;
    start  = 1'b1;
    op     = o;
    a      = x;
    b      = y;
    pend32 = model(32, o, x, y);
    pend8  = model(8, o, x, y)[15:0];
    check("model32", pend32, lit32);
    check("model8", 64'(pend8), 64'(lit8));
    dz32 = o[1] && (y == 32'd0);
    dz8  = o[1] && (y[7:0] == 8'd0);
    keep32 = held32;
    n32 = 0;
    n8  = 0;
    k   = 0;
    @(posedge clk); #1;
    while ((bus32.busy_o || bus8.busy_o) && k < 100) begin
      if (bus32.busy_o) n32++;
      if (bus8.busy_o) n8++;
      if (annul_at >= 0 && n32 == annul_at) begin
        annul = 1'b1;
        start = 1'b0;
        @(posedge clk); #1;
        annul = 1'b0;
        check("annul_busy32", 64'(bus32.busy_o), 64'd0);
        check("annul_ready32", 64'(bus32.ready_o), 64'd0);
        check("annul_ready8", 64'(bus8.ready_o), 64'd0);
        check("annul_keep32", bus32.result_o, keep32);
        @(posedge clk); #1;
        check("annul_idle32", 64'(bus32.ready_o | bus32.busy_o), 64'd0);
        return;
      end
      k++;
      @(posedge clk); #1;
    end
    check("timeout", 64'(k < 100), 64'd1);
    check("lat32", 64'(n32), dz32 ? 64'd0 : 64'd32);
    check("lat8", 64'(n8), dz8 ? 64'd0 : 64'd8);
    check("ready32", 64'(bus32.ready_o), 64'd1);
    check("ready8", 64'(bus8.ready_o), 64'd1);
    check("lit32", bus32.result_o, lit32);
    check("lit8", 64'(bus8.result_o), 64'(lit8));
`ifdef MDU_DIVZERO_FLAG_EN
    check("dz32", 64'(bus32.div_zero_o), 64'(dz32));
    check("dz8", 64'(bus8.div_zero_o), 64'(dz8));
`endif
    repeat (3) begin
      @(posedge clk); #1;
      check("hold_ready32", 64'(bus32.ready_o), 64'd1);
      check("hold_lit32", bus32.result_o, lit32);
    end
    start = 1'b0;
    @(posedge clk); #1;
    check("drop_ready32", 64'(bus32.ready_o), 64'd0);
    check("drop_ready8", 64'(bus8.ready_o), 64'd0);
    check("drop_keep32", bus32.result_o, lit32);
`ifdef MDU_DIVZERO_FLAG_EN
    check("drop_dz32", 64'(bus32.div_zero_o), 64'd0);
`endif
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_res32"}, bus32.result_o, 64'd0);
    check({tag, "_res8"}, 64'(bus8.result_o), 64'd0);
    check({tag, "_rdy"}, 64'({bus32.ready_o, bus8.ready_o}), 64'd0);
    check({tag, "_busy"}, 64'({bus32.busy_o, bus8.busy_o}), 64'd0);
`ifdef MDU_DIVZERO_FLAG_EN
    check({tag, "_dz"}, 64'({bus32.div_zero_o, bus8.div_zero_o}), 64'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst    = 1'b0;
    held32 = 64'd0;
    held8  = 16'd0;
    chk_en = 1'b1;
    @(posedge clk); #1;

    run_op(2'd1, -32'sd7, 32'd3, 64'hFFFFFFFF_FFFFFFEB, 16'hFFEB, -1);
    run_op(2'd2, 32'd100, 32'd7, {32'd2, 32'd14}, 16'h020E, -1);
    run_op(2'd3, -32'sd7, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 16'hFFFD, -1);
    run_op(2'd3, 32'd5, 32'd0, 64'd0, 16'h0000, -1);
    run_op(2'd0, 32'd3, 32'd4, 64'd12, 16'd12, 10);
    run_op(2'd2, 32'd9, 32'd3, 64'd3, 16'h0003, -1);
    run_op(2'd0, 32'd255, 32'd255, 64'h0000_FE01, 16'hFE01, -1);
    run_op(2'd3, -32'sd128, -32'sd1, 64'h80, 16'h0080, -1);
    run_op(2'd3, 32'd7, -32'sd2, {32'd1, 32'hFFFFFFFD}, 16'h01FD, -1);
    run_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 16'hFE01, -1);
    run_op(2'd1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, 16'h0000, -1);

    start  = 1'b1;
    op     = 2'd1;
    a      = 32'd6;
    b      = 32'd7;
    pend32 = model(32, 2'd1, 32'd6, 32'd7);
    pend8  = model(8, 2'd1, 32'd6, 32'd7)[15:0];
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_busy32", 64'(bus32.busy_o), 64'd1);
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    check_reset_state("midrst");
    held32 = 64'd0;
    held8  = 16'd0;
    rst    = 1'b0;
    @(posedge clk); #1;

    run_op(2'd2, 32'd100, 32'd7, {32'd2, 32'd14}, 16'h020E, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
